rr_reg_arbiter: RTL and testbench

//   Round-robin arbiter sharing one D-type output register between NUM_REQ requesters.
//   - Grants register ownership to one requester at a time.
//   - Captures the owner's data into the register every cycle it holds a grant.
//   - Caps ownership at MAX_HOLD cycles when other requesters are waiting.
//   - Sits between per-lane producers and the single downstream register consumer.
//

---
 rtl/rr_reg_arbiter.sv | 140 ++++++++++++++
 tb/tb_rr_reg_arbiter.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/rr_reg_arbiter.sv
// Round-robin arbiter that hands one shared D-type output register to one lane at a time,
// capturing the owner's data every granted cycle and forcing a hand-over after MAX_HOLD captures.
module rr_reg_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int DATA_W   = 8,
    parameter int MAX_HOLD = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_REQ-1:0]          req_i,
    input  logic [NUM_REQ*DATA_W-1:0]   data_i,
    output logic [NUM_REQ-1:0]          gnt_o,
    output logic [$clog2(NUM_REQ)-1:0]  owner_o,
    output logic [DATA_W-1:0]           q_o,
    output logic                        q_valid_o
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t               state_q, state_d;
    logic [NUM_REQ-1:0]   gnt_q, gnt_d;
    logic [IW-1:0]        owner_q, owner_d;
    logic [IW-1:0]        ptr_q, ptr_d;
    logic [DATA_W-1:0]    q_q, q_d;
    logic                 valid_q, valid_d;
    logic [HW-1:0]        hold_q, hold_d;

    logic [DATA_W-1:0]    lane [NUM_REQ];
    logic [NUM_REQ-1:0]   others;
    logic [IW-1:0]        first_win;
    logic [IW-1:0]        next_win;
    logic                 rotate;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_lane
        assign lane[g] = data_i[g*DATA_W +: DATA_W];
    end

    // First set bit of r at or after start, wrapping; callers guarantee r is non-zero.
    function automatic logic [IW-1:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                              input logic [IW-1:0]      start);
        logic [IW-1:0] win;
        logic          found;
        int            idx;
        win   = start;
        found = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = (int'(start) + i) % NUM_REQ;
            if (!found && r[idx]) begin
                win   = IW'(idx);
                found = 1'b1;
            end
        end
        return win;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            owner_q <= '0;
            ptr_q   <= '0;
            q_q     <= '0;
            valid_q <= 1'b0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            q_q     <= q_d;
            valid_q <= valid_d;
            hold_q  <= hold_d;
        end
    end

    // The owner's own bit is masked out, so searching from owner_q starts effectively at owner+1.
    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        owner_d   = owner_q;
        ptr_d     = ptr_q;
        q_d       = q_q;
        valid_d   = 1'b0;
        hold_d    = hold_q;
        rotate    = 1'b0;
        others    = req_i & ~gnt_q;
        first_win = rr_pick(req_i, ptr_q);
        next_win  = rr_pick(others, owner_q);

        case (state_q)
            IDLE: begin
                hold_d = '0;
                if (|req_i) begin
                    state_d = GRANT;
                    gnt_d   = NUM_REQ'(1) << first_win;
                    owner_d = first_win;
                    ptr_d   = first_win;
                end
            end
            GRANT: begin
                if (req_i[owner_q]) begin
                    q_d     = lane[owner_q];
                    valid_d = 1'b1;
                    if (hold_q == HOLD_LAST) begin
                        rotate = |others;
                    end else begin
                        hold_d = hold_q + 1'b1;
                    end
                end else if (|others) begin
                    rotate = 1'b1;
                end else begin
                    state_d = IDLE;
                    gnt_d   = '0;
                    hold_d  = '0;
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase

        if (rotate) begin
            gnt_d   = NUM_REQ'(1) << next_win;
            owner_d = next_win;
            ptr_d   = next_win;
            hold_d  = '0;
        end
    end

    assign gnt_o     = gnt_q;
    assign owner_o   = owner_q;
    assign q_o       = q_q;
    assign q_valid_o = valid_q;

endmodule

// File: tb/tb_rr_reg_arbiter.sv
// Self-checking bench for rr_reg_arbiter: a tenure-counting reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_rr_reg_arbiter;

    localparam int NUM_REQ  = 4;
    localparam int DATA_W   = 8;
    localparam int MAX_HOLD = 4;

    logic                       clk = 1'b0;
    logic                       rst_n = 1'b0;
    logic [NUM_REQ-1:0]         req_i = '0;
    logic [NUM_REQ*DATA_W-1:0]  data_i = '0;
    logic [NUM_REQ-1:0]         gnt_o;
    logic [1:0]                 owner_o;
    logic [DATA_W-1:0]          q_o;
    logic                       q_valid_o;

    int n_cmp  = 0;
    int n_fail = 0;

    rr_reg_arbiter #(
        .NUM_REQ (NUM_REQ),
        .DATA_W  (DATA_W),
        .MAX_HOLD(MAX_HOLD)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req_i    (req_i),
        .data_i   (data_i),
        .gnt_o    (gnt_o),
        .owner_o  (owner_o),
        .q_o      (q_o),
        .q_valid_o(q_valid_o)
    );

    always #5 clk = ~clk;

    // Model tracks who owns the register and how many captures the current tenure has made.
    typedef struct packed {
        logic        busy;
        logic [31:0] owner;
        logic [31:0] tenure;
        logic [7:0]  q;
        logic        valid;
    } model_t;

    model_t m = '0;

    function automatic model_t model_next(input model_t s, input logic [3:0] r, input logic [31:0] d);
        model_t     n;
        logic [3:0] others;
        logic       found;
        int         o;
        int         idx;
        n       = s;
        n.valid = 1'b0;
        o       = int'(s.owner);
        others  = r & ~(4'b0001 << o);
        found   = 1'b0;
        if (!s.busy) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                idx = (o + i) % NUM_REQ;
                if (!found && r[idx]) begin
                    found    = 1'b1;
                    n.busy   = 1'b1;
                    n.owner  = 32'(idx);
                    n.tenure = 32'd0;
                end
            end
        end else begin
            if (r[o]) begin
                n.q      = d[o*8 +: 8];
                n.valid  = 1'b1;
                n.tenure = s.tenure + 32'd1;
            end
            if ((!r[o] || int'(n.tenure) >= MAX_HOLD) && others != 4'b0000) begin
                for (int i = 1; i < NUM_REQ; i++) begin
                    idx = (o + i) % NUM_REQ;
                    if (!found && r[idx]) begin
                        found    = 1'b1;
                        n.owner  = 32'(idx);
                        n.tenure = 32'd0;
                    end
                end
            end else if (!r[o]) begin
                n.busy = 1'b0;
            end
        end
        return n;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m <= '0;
        else        m <= model_next(m, req_i, data_i);
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Every cycle, away from the active edge, the DUT must agree with the model.
    always @(negedge clk) begin
        checkOutput("gnt",    32'(gnt_o),     m.busy ? (32'd1 << m.owner) : 32'd0);
        checkOutput("owner",  32'(owner_o),   m.owner);
        checkOutput("q",      32'(q_o),       32'(m.q));
        checkOutput("valid",  32'(q_valid_o), 32'(m.valid));
        checkOutput("onehot", 32'($countones(gnt_o) <= 1), 32'd1);
    end

    task automatic applyStimulus(input logic [3:0] req, input logic [31:0] data, input int cycles);
        req_i  = req;
        data_i = data;
        repeat (cycles) @(posedge clk);
        #1;
    endtask

    logic [3:0] tbl_req [10] = '{4'b0110, 4'b1111, 4'b1010, 4'b0000, 4'b1000,
                                 4'b1100, 4'b0101, 4'b0001, 4'b1011, 4'b0111};
    int         tbl_len [10] = '{3, 6, 5, 2, 2, 7, 3, 1, 9, 4};

    initial begin
        int vcount;
        logic [31:0] d4;
        d4 = 32'h44332211;

        $display("[TB] reset state");
        applyStimulus(4'b0000, 32'h0, 3);
        checkOutput("rst_gnt",   32'(gnt_o),     32'd0);
        checkOutput("rst_owner", 32'(owner_o),   32'd0);
        checkOutput("rst_q",     32'(q_o),       32'd0);
        checkOutput("rst_valid", 32'(q_valid_o), 32'd0);
        rst_n = 1'b1;

        $display("[TB] single request");
        applyStimulus(4'b0001, 32'h000000A5, 1);
        checkOutput("single_gnt",   32'(gnt_o),     32'h1);
        checkOutput("single_valid0", 32'(q_valid_o), 32'd0);
        applyStimulus(4'b0001, 32'h000000A5, 1);
        checkOutput("single_q",     32'(q_o),       32'hA5);
        checkOutput("single_valid", 32'(q_valid_o), 32'd1);
        applyStimulus(4'b0000, 32'h000000A5, 1);
        checkOutput("idle_gnt", 32'(gnt_o), 32'd0);
        checkOutput("idle_q",   32'(q_o),   32'hA5);

        $display("[TB] fairness");
        applyStimulus(4'b1111, d4, 1);
        checkOutput("fair_g0", 32'(gnt_o), 32'h1);
        applyStimulus(4'b1111, d4, 4);
        checkOutput("fair_g1", 32'(gnt_o), 32'h2);
        checkOutput("fair_q0", 32'(q_o),   32'h11);
        applyStimulus(4'b1111, d4, 4);
        checkOutput("fair_g2", 32'(gnt_o), 32'h4);
        checkOutput("fair_q1", 32'(q_o),   32'h22);
        applyStimulus(4'b1111, d4, 4);
        checkOutput("fair_g3", 32'(gnt_o), 32'h8);
        applyStimulus(4'b1111, d4, 4);
        checkOutput("fair_g4", 32'(gnt_o), 32'h1);
        checkOutput("fair_q3", 32'(q_o),   32'h44);

        $display("[TB] early release");
        applyStimulus(4'b0000, d4, 1);
        applyStimulus(4'b0100, d4, 1);
        checkOutput("early_g2", 32'(gnt_o), 32'h4);
        applyStimulus(4'b0101, d4, 2);
        checkOutput("early_q2", 32'(q_o), 32'h33);
        applyStimulus(4'b0001, d4, 1);
        checkOutput("early_g0",    32'(gnt_o),     32'h1);
        checkOutput("early_novld", 32'(q_valid_o), 32'd0);
        applyStimulus(4'b1001, d4, 3);
        checkOutput("early_keep", 32'(gnt_o), 32'h1);
        applyStimulus(4'b1001, d4, 1);
        checkOutput("early_yield", 32'(gnt_o), 32'h8);

        $display("[TB] solo hold");
        applyStimulus(4'b0000, d4, 1);
        applyStimulus(4'b0010, d4, 1);
        checkOutput("solo_gnt0", 32'(gnt_o), 32'h2);
        vcount = 0;
        for (int i = 0; i < 20; i++) begin
            applyStimulus(4'b0010, 32'h5A0000C3 | (32'(8'h80 + i) << 8), 1);
            checkOutput("solo_gnt", 32'(gnt_o), 32'h2);
            checkOutput("solo_q",   32'(q_o),   32'(8'h80 + i));
            if (q_valid_o) vcount++;
        end
        checkOutput("solo_captures", 32'(vcount), 32'd20);

        $display("[TB] drain");
        applyStimulus(4'b0000, 32'h0, 1);
        checkOutput("drain_gnt",   32'(gnt_o),     32'd0);
        checkOutput("drain_valid", 32'(q_valid_o), 32'd0);
        checkOutput("drain_q",     32'(q_o),       32'h93);
        checkOutput("drain_owner", 32'(owner_o),   32'd1);

        $display("[TB] mixed request table");
        for (int i = 0; i < 10; i++) begin
            applyStimulus(tbl_req[i], 32'hD0C0B0A0 + 32'h01010101 * 32'(i), tbl_len[i]);
        end

        $display("[TB] reset mid-grant");
        applyStimulus(4'b1111, d4, 3);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("arst_gnt",   32'(gnt_o),     32'd0);
        checkOutput("arst_owner", 32'(owner_o),   32'd0);
        checkOutput("arst_q",     32'(q_o),       32'd0);
        checkOutput("arst_valid", 32'(q_valid_o), 32'd0);
        applyStimulus(4'b1111, d4, 2);
        checkOutput("arst_hold_q", 32'(q_o), 32'd0);
        rst_n = 1'b1;
        applyStimulus(4'b0000, d4, 2);
        checkOutput("post_gnt", 32'(gnt_o), 32'd0);
        applyStimulus(4'b0100, d4, 1);
        checkOutput("post_g2", 32'(gnt_o), 32'h4);
        applyStimulus(4'b0000, d4, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
